// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// shifts them out MSB first, flagging first/last bit of each frame.
module serial_word_feeder #(
  parameter int WIDTH    = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a word moves on the rising edge where word_valid && word_ready;
  // word_ready never depends on word_valid, and word_in is sampled only then.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;

  logic last_bit;
  logic gap_done;
  logic transfer;

  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);
  assign gap_done = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);
  assign transfer = word_valid && word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (transfer) begin
          state_d   = S_SHIFT;
          shreg_d   = word_in;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (IDLE_GAP == 0) begin
          // Back-to-back: a word accepted on the last bit starts immediately.
          bit_cnt_d = '0;
          if (transfer) begin
            shreg_d = word_in;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d   = S_GAP;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          gap_cnt_d = '0;
          if (transfer) begin
            state_d   = S_SHIFT;
            shreg_d   = word_in;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    word_ready  = 1'b0;
    data_out    = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        word_ready = 1'b1;
      end
      S_SHIFT: begin
        bit_valid   = 1'b1;
        data_out    = shreg_q[WIDTH-1];
        frame_start = (bit_cnt_q == '0);
        frame_end   = last_bit;
        word_ready  = last_bit && (IDLE_GAP == 0);
      end
      S_GAP: begin
        word_ready = gap_done;
      end
      default: begin
        word_ready = 1'b0;
      end
    endcase
    // State is already IDLE during reset; keep ready low until release.
    if (reset) begin
      word_ready = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
